microprocessor_character_transmitter: RTL and testbench

MICROPROCESSOR_CHARACTER_TRANSMITTER -- requirements
Module: microprocessor_character_transmitter

---
 rtl/microprocessor_character_transmitter_pkg.sv | 30 +++
 rtl/char_tx_fifo.sv | 57 +++++
 rtl/microprocessor_character_transmitter.sv | 183 ++++++++++++++++++
 tb/tb_microprocessor_character_transmitter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/microprocessor_character_transmitter_pkg.sv
// Shared types and constants for the character transmitter.
// Optional even parity is compiled in with CHAR_TX_PARITY_EN.
package microprocessor_character_transmitter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef CHAR_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_LEVEL_LSB = 3;
  localparam int STAT_LEVEL_MSB = 7;

`ifdef CHAR_TX_PARITY_EN
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

endpackage

// File: rtl/char_tx_fifo.sv
// First-word-fall-through character FIFO; simultaneous push and pop are
// both honoured even when full.
module char_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  output logic [4:0] level
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [4:0]    level_r;
  logic          do_pop_s;
  logic          do_push_s;

  assign empty     = (level_r == 5'd0);
  assign full      = (level_r == 5'(DEPTH));
  assign level     = level_r;
  assign dout      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= 5'd0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + 5'd1;
        2'b01:   level_r <= level_r - 5'd1;
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/microprocessor_character_transmitter.sv
// Avalon-MM character transmitter: FIFO-buffered 8N1 serializer.
// Define CHAR_TX_PARITY_EN to add an even-parity bit (8E1 frames).
module microprocessor_character_transmitter
  import microprocessor_character_transmitter_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        txd,
  output logic        char_sent
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_t   state_r, state_n;
  logic [15:0] baud_r, baud_n;
  logic [2:0]  bit_idx_r, bit_idx_n;
  logic [7:0]  data_r, data_n;
  logic        txd_r, txd_n;
  logic        char_sent_r, char_sent_n;
  logic        overflow_r;
  logic [31:0] readdata_r, readdata_n;
  logic [31:0] status_s;
  logic        write_s, push_s, pop_s, ovf_clr_s, bit_tick_s;
  logic [7:0]  fifo_dout_s;
  logic        fifo_full_s, fifo_empty_s;
  logic [4:0]  fifo_level_s;
  logic        unused_s;

  assign write_s    = chipselect && !write_n;
  assign push_s     = write_s && (address == ADDR_DATA);
  assign ovf_clr_s  = write_s && (address == ADDR_STATUS) && writedata[2];
  assign bit_tick_s = (baud_r == BAUD_LAST);
  assign unused_s   = ^writedata[31:8];

  char_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_s),
    .pop     (pop_s),
    .din     (writedata[7:0]),
    .dout    (fifo_dout_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .level   (fifo_level_s)
  );

  // Serializer next state; txd and char_sent are derived from the next state
  // so the registered outputs line up with the state they describe.
  always_comb begin
    state_n   = state_r;
    baud_n    = 16'd0;
    bit_idx_n = bit_idx_r;
    data_n    = data_r;
    pop_s     = 1'b0;
    if (state_r != ST_IDLE) begin
      baud_n = bit_tick_s ? 16'd0 : (baud_r + 16'd1);
    end else begin
      baud_n = 16'd0;
    end
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          data_n  = fifo_dout_s;
          state_n = ST_START;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_tick_s) begin
          state_n   = ST_DATA;
          bit_idx_n = 3'd0;
        end else begin
          state_n = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_tick_s && (bit_idx_r == 3'd7)) begin
`ifdef CHAR_TX_PARITY_EN
          state_n = ST_PARITY;
`else
          state_n = ST_STOP;
`endif
        end else if (bit_tick_s) begin
          bit_idx_n = bit_idx_r + 3'd1;
        end else begin
          state_n = ST_DATA;
        end
      end
`ifdef CHAR_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_tick_s) begin
          state_n = ST_STOP;
        end else begin
          state_n = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (bit_tick_s && !fifo_empty_s) begin
          pop_s   = 1'b1;
          data_n  = fifo_dout_s;
          state_n = ST_START;
        end else if (bit_tick_s) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_STOP;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    case (state_n)
      ST_START:  txd_n = 1'b0;
      ST_DATA:   txd_n = data_n[bit_idx_n];
`ifdef CHAR_TX_PARITY_EN
      ST_PARITY: txd_n = even_parity(data_n);
`endif
      default:   txd_n = 1'b1;
    endcase
    char_sent_n = (state_n == ST_STOP) && (baud_n == BAUD_LAST);
  end

  // Status word and read mux.
  always_comb begin
    status_s                                = 32'd0;
    status_s[STAT_BUSY]                     = !fifo_empty_s || (state_r != ST_IDLE);
    status_s[STAT_FULL]                     = fifo_full_s;
    status_s[STAT_OVERFLOW]                 = overflow_r;
    status_s[STAT_LEVEL_MSB:STAT_LEVEL_LSB] = fifo_level_s;
    case (address)
      ADDR_STATUS: readdata_n = status_s;
      default:     readdata_n = 32'd0;
    endcase
  end

  // Serializer and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      baud_r      <= 16'd0;
      bit_idx_r   <= 3'd0;
      data_r      <= 8'd0;
      txd_r       <= 1'b1;
      char_sent_r <= 1'b0;
      readdata_r  <= 32'd0;
    end else begin
      state_r     <= state_n;
      baud_r      <= baud_n;
      bit_idx_r   <= bit_idx_n;
      data_r      <= data_n;
      txd_r       <= txd_n;
      char_sent_r <= char_sent_n;
      readdata_r  <= readdata_n;
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r <= 1'b0;
    end else if (push_s && fifo_full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end else if (ovf_clr_s) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign txd       = txd_r;
  assign char_sent = char_sent_r;
  assign readdata  = readdata_r;

endmodule

// File: tb/tb_microprocessor_character_transmitter.sv
// Self-checking bench: a UART-receiver monitor compares each frame against
// the expected character queue built from the writes.
module tb_microprocessor_character_transmitter;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef CHAR_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        txd;
  logic        char_sent;

  int vectors = 0;
  int miscompares = 0;
  int rx_count = 0;
  int cs_count = 0;
  int gapless = 0;
  logic [7:0] exp_q[$];

  logic        mon_active = 1'b0;
  logic        mon_ended = 1'b0;
  int          mon_cnt = 0;
  logic [10:0] mon_frame = 11'h7FF;

  microprocessor_character_transmitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .txd(txd), .char_sent(char_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Line-level frame: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    logic [10:0] f;
    f = 11'h7FF;
    f[0] = 1'b0;
    f[8:1] = d;
`ifdef CHAR_TX_PARITY_EN
    f[9] = ^d;
`endif
    return f;
  endfunction

  // Receiver monitor, sampling mid-bit on the falling edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      mon_active = 1'b0;
      mon_ended  = 1'b0;
    end else begin
      if (char_sent) cs_count++;
      if (!mon_active) begin
        if (txd == 1'b0) begin
          if (mon_ended) gapless++;
          mon_active = 1'b1;
          mon_cnt = 0;
          check("frame_expected", {31'd0, exp_q.size() > 0}, 32'd1);
          if (exp_q.size() > 0) mon_frame = frame_bits(exp_q.pop_front());
          else mon_frame = 11'h7FF;
        end
        mon_ended = 1'b0;
      end else begin
        mon_cnt++;
        if ((mon_cnt % CPB) == (CPB / 2))
          check($sformatf("txd_bit%0d", mon_cnt / CPB), {31'd0, txd}, {31'd0, mon_frame[mon_cnt / CPB]});
        if (mon_cnt == NB * CPB - 1) begin
          check("char_sent_at_stop_end", {31'd0, char_sent}, 32'd1);
          mon_active = 1'b0;
          mon_ended  = 1'b1;
          rx_count++;
        end
      end
    end
  end

  // Called at posedge+1; performs one write on the next edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
    address = a;
    @(posedge clk); #1;
    v = readdata;
  endtask

  task automatic wait_frames(input int base, input int n);
    int budget;
    budget = n * NB * CPB + 60;
    while ((rx_count - base) < n && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    repeat (3) @(posedge clk);
    #1;
    check("frames_received", rx_count - base, n);
    check("exp_queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [31:0] v;
    int base, csb, gb, n, budget;
    logic [7:0] b;

    repeat (3) @(posedge clk);
    #1;
    check("reset_readdata", readdata, 32'd0);
    check("reset_txd", {31'd0, txd}, 32'd1);
    check("reset_char_sent", {31'd0, char_sent}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    read_reg(2'd1, v);
    check("status_after_reset", v, 32'd0);

    // Single 0x55 frame.
    base = rx_count; csb = cs_count;
    exp_q.push_back(8'h55);
    bus_write(2'd0, 32'h0000_0055);
    wait_frames(base, 1);
    check("char_sent_once", cs_count - csb, 1);
    read_reg(2'd1, v);
    check("busy_cleared", v, 32'd0);
    read_reg(2'd0, v);
    check("addr0_reads_zero", v, 32'd0);

    // Back-to-back frames with no idle bit between them.
    base = rx_count; csb = cs_count; gb = gapless;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h41 + 8'(i));
      bus_write(2'd0, 32'h41 + 32'(i));
    end
    wait_frames(base, 3);
    check("three_char_sent", cs_count - csb, 3);
    check("no_idle_between", gapless - gb, 2);

    // Overflow: first char popped at once, four fill the FIFO, sixth dropped.
    base = rx_count;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_q.push_back(8'h10 + 8'(i));
      bus_write(2'd0, 32'h10 + 32'(i));
    end
    read_reg(2'd1, v);
    check("status_overflow", v, 32'h27);
    bus_write(2'd1, 32'h4);
    read_reg(2'd1, v);
    check("status_ovf_cleared", v, 32'h23);
    read_reg(2'd2, v);
    check("addr2_reads_zero", v, 32'd0);
    wait_frames(base, 5);

    // Push coinciding with pop while full.
    base = rx_count;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      bus_write(2'd0, 32'h20 + 32'(i));
    end
    read_reg(2'd1, v);
    check("status_full", v, 32'h23);
    address = 2'd0;
    budget = 2 * NB * CPB;
    while (!char_sent && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("char_sent_seen", {31'd0, char_sent}, 32'd1);
    exp_q.push_back(8'h25);
    bus_write(2'd0, 32'h25);
    read_reg(2'd1, v);
    check("level_held_at_full", v, 32'h23);
    wait_frames(base, 6);

    // Reset during data bit 3 of 0xA5 with two entries queued.
    base = rx_count;
    exp_q.push_back(8'hA5);
    bus_write(2'd0, 32'hA5);
    bus_write(2'd0, 32'h01);
    bus_write(2'd0, 32'h02);
    repeat (16) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_txd_immediate", {31'd0, txd}, 32'd1);
    check("reset_char_sent", {31'd0, char_sent}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    read_reg(2'd1, v);
    check("status_after_abort", v, 32'd0);
    repeat (3 * NB * CPB) @(posedge clk);
    #1;
    check("no_frame_after_reset", rx_count - base, 0);
    check("txd_idle_after_reset", {31'd0, txd}, 32'd1);

`ifdef CHAR_TX_PARITY_EN
    base = rx_count;
    exp_q.push_back(8'h07);
    bus_write(2'd0, 32'h07);
    wait_frames(base, 1);
`endif

    // Random bursts of up to five characters from idle.
    for (int k = 0; k < 4; k++) begin
      base = rx_count;
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        bus_write(2'd0, {24'd0, b});
      end
      wait_frames(base, n);
      read_reg(2'd1, v);
      check("random_status_idle", v, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
